// File: rtl/eth_capture_framer.sv
// Packs an RMII byte stream into 32-bit words, issues per-chunk DMA commands and a per-packet
// trailer in chunk 0 of the slot. Define ETH_FRAMER_TIMESTAMP_EN for timestamped trailers.
module eth_capture_framer #(
  parameter int unsigned BURST   = 16,
  parameter int unsigned SLOT_W  = 10,
  parameter int unsigned CHUNK_W = 6
) (
  input  logic                        clk50,
  input  logic                        reset,
  input  logic                        rxsop,
  input  logic                        rxeop,
  input  logic                        rxvalid,
  input  logic [7:0]                  rxdata,
  input  logic                        enable,
  input  logic                        dfifo_afull,
  input  logic                        cfifo_afull,
  output logic [31:0]                 dout,
  output logic                        dout_wr,
  output logic [4+SLOT_W+CHUNK_W-1:0] cmd_out,
  output logic                        cmd_wr,
  output logic [15:0]                 drop_count
);

  localparam logic [3:0]         BurstLast  = 4'(BURST - 1);
  localparam logic [4:0]         WordLast   = 5'(BURST - 1);
  localparam logic [CHUNK_W-1:0] ChunkLast  = {CHUNK_W{1'b1}};
  localparam logic [CHUNK_W-1:0] ChunkFirst = CHUNK_W'(1);
`ifdef ETH_FRAMER_TIMESTAMP_EN
  localparam logic [3:0]         TrlLast    = 4'd3;
`else
  localparam logic [3:0]         TrlLast    = 4'd1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    FLUSH,
    TRL_LEN,
`ifdef ETH_FRAMER_TIMESTAMP_EN
    TRL_TSLO,
    TRL_TSHI,
`endif
    TRL_STAT,
    DROP
  } state_t;

  state_t               state;
  logic [23:0]          pend;
  logic [1:0]           byte_idx;
  logic [4:0]           word_cnt;
  logic [CHUNK_W-1:0]   chunk;
  logic [SLOT_W-1:0]    slot;
  logic [15:0]          bytecount;
  logic                 truncated;
  logic                 aborted;
  logic                 data_full;
`ifdef ETH_FRAMER_TIMESTAMP_EN
  logic [63:0]          timestamp;
  logic [63:0]          ts_cap;
`endif

  logic        accept;
  logic        drop_evt;
  logic        has_part;
  logic [4:0]  flush_words;
  logic [15:0] drop_next;
  logic [15:0] count_next;

  assign accept      = enable & ~dfifo_afull & ~cfifo_afull;
  // Any rxsop that does not start a capture from IDLE is a dropped packet.
  assign drop_evt    = rxsop & ~((state == IDLE) & accept);
  assign has_part    = (byte_idx != 2'd0);
  assign flush_words = word_cnt + {4'd0, has_part};
  assign drop_next   = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
  assign count_next  = (bytecount == 16'hFFFF) ? bytecount : bytecount + 16'd1;

`ifdef ETH_FRAMER_TIMESTAMP_EN
  always_ff @(posedge clk50) begin
    if (reset) timestamp <= '0;
    else       timestamp <= timestamp + 64'd1;
  end
`endif

  always_ff @(posedge clk50) begin
    if (reset) begin
      state      <= IDLE;
      dout       <= '0;
      dout_wr    <= 1'b0;
      cmd_out    <= '0;
      cmd_wr     <= 1'b0;
      drop_count <= '0;
      slot       <= '0;
      chunk      <= ChunkFirst;
      pend       <= '0;
      byte_idx   <= '0;
      word_cnt   <= '0;
      bytecount  <= '0;
      truncated  <= 1'b0;
      aborted    <= 1'b0;
      data_full  <= 1'b0;
`ifdef ETH_FRAMER_TIMESTAMP_EN
      ts_cap     <= '0;
`endif
    end else begin
      dout_wr <= 1'b0;
      cmd_wr  <= 1'b0;
      if (drop_evt) drop_count <= drop_next;
      unique case (state)
        IDLE: begin
          if (rxsop && accept) begin
            state     <= rxeop ? FLUSH : DATA;
            pend      <= {16'h0, rxvalid ? rxdata : 8'h00};
            byte_idx  <= {1'b0, rxvalid};
            word_cnt  <= '0;
            bytecount <= {15'h0, rxvalid};
            truncated <= 1'b0;
            aborted   <= 1'b0;
            data_full <= 1'b0;
`ifdef ETH_FRAMER_TIMESTAMP_EN
            ts_cap    <= timestamp;
`endif
          end else if (rxsop && !rxeop) begin
            state <= DROP;
          end
        end
        DATA: begin
          if (rxsop) begin
            aborted <= 1'b1;
            state   <= FLUSH;
          end else begin
            if (rxvalid) begin
              bytecount <= count_next;
              if (data_full) begin
                truncated <= 1'b1;
              end else if (byte_idx == 2'd3) begin
                dout     <= {rxdata, pend};
                dout_wr  <= 1'b1;
                pend     <= '0;
                byte_idx <= '0;
                if (word_cnt == WordLast) begin
                  cmd_wr   <= 1'b1;
                  cmd_out  <= {BurstLast, slot, chunk};
                  word_cnt <= '0;
                  // Last chunk stays put; later bytes are only counted.
                  if (chunk == ChunkLast) data_full <= 1'b1;
                  else                    chunk     <= chunk + 1'b1;
                end else begin
                  word_cnt <= word_cnt + 5'd1;
                end
              end else begin
                pend[{byte_idx, 3'b000} +: 8] <= rxdata;
                byte_idx <= byte_idx + 2'd1;
              end
            end
            if (rxeop) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (has_part) begin
            dout    <= {8'h00, pend};
            dout_wr <= 1'b1;
          end
          if (flush_words != 5'd0) begin
            cmd_wr  <= 1'b1;
            cmd_out <= {4'(flush_words - 5'd1), slot, chunk};
          end
          pend     <= '0;
          byte_idx <= '0;
          state    <= TRL_LEN;
        end
        TRL_LEN: begin
          dout    <= {16'h0, bytecount};
          dout_wr <= 1'b1;
`ifdef ETH_FRAMER_TIMESTAMP_EN
          state   <= TRL_TSLO;
`else
          state   <= TRL_STAT;
`endif
        end
`ifdef ETH_FRAMER_TIMESTAMP_EN
        TRL_TSLO: begin
          dout    <= ts_cap[31:0];
          dout_wr <= 1'b1;
          state   <= TRL_TSHI;
        end
        TRL_TSHI: begin
          dout    <= ts_cap[63:32];
          dout_wr <= 1'b1;
          state   <= TRL_STAT;
        end
`endif
        TRL_STAT: begin
          dout    <= {29'h0, aborted, truncated, 1'b1};
          dout_wr <= 1'b1;
          cmd_wr  <= 1'b1;
          cmd_out <= {TrlLast, slot, {CHUNK_W{1'b0}}};
          slot    <= slot + 1'b1;
          chunk   <= ChunkFirst;
          state   <= IDLE;
        end
        DROP: begin
          if (rxeop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_capture_framer.sv
// Bench for eth_capture_framer: a table of packet vectors plus hand sequences for drops during
// flush, abort, truncation, slot wrap and mid-packet reset; expectations built from length/base.
module tb_eth_capture_framer;

  localparam int BURST     = 16;
  localparam int SLOT_W    = 10;
  localparam int CHUNK_W   = 6;
  localparam int CW        = 4 + SLOT_W + CHUNK_W;
  localparam int CAP_BYTES = (2 ** CHUNK_W - 1) * BURST * 4;
`ifdef ETH_FRAMER_TIMESTAMP_EN
  localparam int TRLW      = 4;
`else
  localparam int TRLW      = 2;
`endif

  logic          clk50 = 1'b0;
  logic          reset;
  logic          rxsop, rxeop, rxvalid;
  logic [7:0]    rxdata;
  logic          enable, dfifo_afull, cfifo_afull;
  logic [31:0]   dout;
  logic          dout_wr;
  logic [CW-1:0] cmd_out;
  logic          cmd_wr;
  logic [15:0]   drop_count;

  always #10 clk50 = ~clk50;

  eth_capture_framer dut (
    .clk50       (clk50),
    .reset       (reset),
    .rxsop       (rxsop),
    .rxeop       (rxeop),
    .rxvalid     (rxvalid),
    .rxdata      (rxdata),
    .enable      (enable),
    .dfifo_afull (dfifo_afull),
    .cfifo_afull (cfifo_afull),
    .dout        (dout),
    .dout_wr     (dout_wr),
    .cmd_out     (cmd_out),
    .cmd_wr      (cmd_wr),
    .drop_count  (drop_count)
  );

  logic [31:0]   dq[$];
  logic [CW-1:0] cq[$];

  always @(negedge clk50) begin
    if (dout_wr) dq.push_back(dout);
    if (cmd_wr)  cq.push_back(cmd_out);
  end

`ifdef ETH_FRAMER_TIMESTAMP_EN
  logic [63:0] ts_model;
  logic [63:0] pkt_ts;
  always @(posedge clk50) ts_model <= reset ? 64'd0 : ts_model + 64'd1;
`endif

  int n_pass   = 0;
  int n_checks = 0;
  int exp_slot = 0;
  int exp_drops = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic idle_inputs();
    rxsop   = 1'b0;
    rxeop   = 1'b0;
    rxvalid = 1'b0;
    rxdata  = 8'h00;
  endtask

  // Timestamp the DUT will latch on the next edge.
  task automatic mark_ts();
`ifdef ETH_FRAMER_TIMESTAMP_EN
    pkt_ts = ts_model;
`endif
  endtask

  task automatic drive_bytes(input int len, input logic [7:0] base, input bit sop, input bit eop);
    for (int i = 0; i < len; i++) begin
      rxsop   = sop && (i == 0);
      rxeop   = eop && (i == len - 1);
      rxvalid = 1'b1;
      rxdata  = base + 8'(i);
      tick();
    end
    idle_inputs();
  endtask

  // Full packet with per-byte strobe timing checks; en_mid drops enable/raises afull after sop.
  task automatic send_pkt(input string name, input int len, input logic [7:0] base,
                          input bit cap, input bit en_mid);
    int terr = 0;
    bit exp_dw, exp_cw;
    mark_ts();
    for (int i = 0; i < len; i++) begin
      rxsop   = (i == 0);
      rxeop   = (i == len - 1);
      rxvalid = 1'b1;
      rxdata  = base + 8'(i);
      tick();
      if (i == 0 && en_mid) begin
        enable = 1'b0; dfifo_afull = 1'b1; cfifo_afull = 1'b1;
      end
      exp_dw = cap && (i % 4 == 3) && (i < CAP_BYTES);
      exp_cw = cap && ((i + 1) % (4 * BURST) == 0) && (i < CAP_BYTES);
      if (dout_wr !== exp_dw || cmd_wr !== exp_cw) terr++;
    end
    idle_inputs();
    if (en_mid) begin
      enable = 1'b1; dfifo_afull = 1'b0; cfifo_afull = 1'b0;
    end
    check({name, " strobe timing errors"}, 64'(terr), 64'd0);
    repeat (8) tick();
  endtask

  task automatic check_pkt(input string name, input int len, input logic [7:0] base,
                           input int slot, input bit ab);
    int stored, nw, nfull, rem, ncmd, len16;
    bit trunc;
    logic [31:0]   exp_w;
    logic [CW-1:0] exp_c;
    stored = (len > CAP_BYTES) ? CAP_BYTES : len;
    trunc  = (len > CAP_BYTES);
    nw     = (stored + 3) / 4;
    nfull  = nw / BURST;
    rem    = nw % BURST;
    ncmd   = nfull + ((rem != 0) ? 1 : 0);
    len16  = (len > 65535) ? 65535 : len;
    check({name, " word count"}, 64'(dq.size()), 64'(nw + TRLW));
    check({name, " cmd count"}, 64'(cq.size()), 64'(ncmd + 1));
    if (dq.size() == nw + TRLW) begin
      for (int j = 0; j < nw; j++) begin
        exp_w = '0;
        for (int b = 0; b < 4; b++)
          if (4 * j + b < stored) exp_w[8*b +: 8] = base + 8'(4 * j + b);
        check($sformatf("%s data[%0d]", name, j), 64'(dq.pop_front()), 64'(exp_w));
      end
      check({name, " trailer length"}, 64'(dq.pop_front()), 64'({16'h0, 16'(len16)}));
`ifdef ETH_FRAMER_TIMESTAMP_EN
      check({name, " trailer ts lo"}, 64'(dq.pop_front()), 64'(pkt_ts[31:0]));
      check({name, " trailer ts hi"}, 64'(dq.pop_front()), 64'(pkt_ts[63:32]));
`endif
      check({name, " trailer status"}, 64'(dq.pop_front()), 64'({29'h0, ab, trunc, 1'b1}));
    end
    if (cq.size() == ncmd + 1) begin
      for (int c = 0; c < nfull; c++) begin
        exp_c = {4'(BURST - 1), SLOT_W'(slot), CHUNK_W'(c + 1)};
        check($sformatf("%s cmd[%0d]", name, c), 64'(cq.pop_front()), 64'(exp_c));
      end
      if (rem != 0) begin
        exp_c = {4'(rem - 1), SLOT_W'(slot), CHUNK_W'(nfull + 1)};
        check({name, " partial cmd"}, 64'(cq.pop_front()), 64'(exp_c));
      end
      exp_c = {4'(TRLW - 1), SLOT_W'(slot), CHUNK_W'(0)};
      check({name, " trailer cmd"}, 64'(cq.pop_front()), 64'(exp_c));
    end
    dq.delete();
    cq.delete();
  endtask

  typedef struct {
    int         len;
    logic [7:0] base;
    bit         en;
    bit         dafull;
    bit         cafull;
    bit         en_mid;
    bit         cap;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    string nm;
    vecs[0] = '{64,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{5,   8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{100, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{7,   8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1,   8'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{12,  8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{9,   8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{68,  8'h50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{8,   8'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{128, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    enable = 1'b1; dfifo_afull = 1'b0; cfifo_afull = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check("reset dout", 64'(dout), 64'd0);
    check("reset dout_wr", 64'(dout_wr), 64'd0);
    check("reset cmd_out", 64'(cmd_out), 64'd0);
    check("reset cmd_wr", 64'(cmd_wr), 64'd0);
    check("reset drop_count", 64'(drop_count), 64'd0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 10; k++) begin
      nm = $sformatf("vec%0d", k);
      enable = vecs[k].en; dfifo_afull = vecs[k].dafull; cfifo_afull = vecs[k].cafull;
      send_pkt(nm, vecs[k].len, vecs[k].base, vecs[k].cap, vecs[k].en_mid);
      enable = 1'b1; dfifo_afull = 1'b0; cfifo_afull = 1'b0;
      if (vecs[k].cap) begin
        check_pkt(nm, vecs[k].len, vecs[k].base, exp_slot, 1'b0);
        exp_slot++;
      end else begin
        check({nm, " dropped data writes"}, 64'(dq.size()), 64'd0);
        check({nm, " dropped cmd writes"}, 64'(cq.size()), 64'd0);
        dq.delete(); cq.delete();
        exp_drops++;
      end
      check({nm, " drop_count"}, 64'(drop_count), 64'(exp_drops));
    end

    // New rxsop while the previous packet is flushing is dropped.
    mark_ts();
    drive_bytes(4, 8'h60, 1'b1, 1'b1);
    drive_bytes(1, 8'hEE, 1'b1, 1'b1);
    repeat (8) tick();
    exp_drops++;
    check_pkt("flushdrop", 4, 8'h60, exp_slot, 1'b0);
    exp_slot++;
    check("flushdrop drop_count", 64'(drop_count), 64'(exp_drops));

    // rxsop after 10 bytes aborts the first packet and drops the second.
    mark_ts();
    drive_bytes(10, 8'h70, 1'b1, 1'b0);
    drive_bytes(20, 8'h90, 1'b1, 1'b1);
    repeat (8) tick();
    exp_drops++;
    check_pkt("abort", 10, 8'h70, exp_slot, 1'b1);
    exp_slot++;
    check("abort drop_count", 64'(drop_count), 64'(exp_drops));

    // Overflow of the last chunk: 8 bytes discarded but counted.
    send_pkt("trunc", CAP_BYTES + 8, 8'h05, 1'b1, 1'b0);
    check_pkt("trunc", CAP_BYTES + 8, 8'h05, exp_slot, 1'b0);
    exp_slot++;

    // Walk the slot index up to its last value, then across the wrap.
    while (exp_slot < 2 ** SLOT_W - 1) begin
      drive_bytes(1, 8'h33, 1'b1, 1'b1);
      repeat (7) tick();
      exp_slot++;
    end
    dq.delete(); cq.delete();
    send_pkt("slotlast", 5, 8'h11, 1'b1, 1'b0);
    check_pkt("slotlast", 5, 8'h11, exp_slot, 1'b0);
    exp_slot = 0;
    send_pkt("slotwrap", 3, 8'hD0, 1'b1, 1'b0);
    check_pkt("slotwrap", 3, 8'hD0, exp_slot, 1'b0);
    exp_slot++;

    // Reset in the middle of a packet; its tail must produce nothing.
    drive_bytes(30, 8'hB0, 1'b1, 1'b0);
    repeat (2) tick();
    dq.delete(); cq.delete();
    reset = 1'b1;
    tick();
    tick();
    check("midreset dout", 64'(dout), 64'd0);
    check("midreset cmd_out", 64'(cmd_out), 64'd0);
    reset = 1'b0;
    drive_bytes(10, 8'hCE, 1'b0, 1'b1);
    repeat (8) tick();
    check("midreset data writes", 64'(dq.size()), 64'd0);
    check("midreset cmd writes", 64'(cq.size()), 64'd0);
    check("midreset drop_count", 64'(drop_count), 64'd0);
    dq.delete(); cq.delete();
    exp_slot = 0;
    exp_drops = 0;
    send_pkt("postreset", 6, 8'h01, 1'b1, 1'b0);
    check_pkt("postreset", 6, 8'h01, exp_slot, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
